wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, the long-latency result queue depth (power of two, 2..8).
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 4, the head-wait cycle count that raises stall_req.
REQ-003 The block SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 The block SHALL have ports alu_we in 1, alu_waddr in 5, alu_wdata in 32: the single-cycle ALU result, with no backpressure.
REQ-006 The block SHALL have ports lu_valid in 1, lu_ready out 1, lu_waddr in 5, lu_wdata in 32: the long-latency (MDU/load) result, valid/ready handshake.
REQ-007 The block SHALL have ports issue_we in 1, issue_waddr in 5: a long-latency op issued targeting issue_waddr.
REQ-008 The block SHALL have ports rf_we out 1, rf_waddr out 5, rf_wdata out 32: the register file write port.
REQ-009 The block SHALL have port busy_mask  out  32  registers with an outstanding long-latency write.
REQ-010 The block SHALL have port stall_req  out  1  requests a one-cycle pipeline bubble so the queue can drain.
REQ-011 The block SHALL have port fifo_count  out  4  current queue occupancy.

Function
REQ-012 rf_we/rf_waddr/rf_wdata SHALL be registered: a request selected in cycle N appears on the write port in cycle N+1.
REQ-013 ALU SHALL have absolute priority: alu_we=1 with alu_waddr!=0 selects the ALU write that cycle.
REQ-014 Otherwise, a non-empty queue SHALL pop its head into the write port that cycle.
REQ-015 With neither source selected, rf_we SHALL be 0 next cycle; rf_waddr/rf_wdata then hold their prior values.
REQ-016 ALU writes to register 0 SHALL be dropped and SHALL NOT block a queue pop.
REQ-017 lu_ready SHALL equal (fifo_count < FIFO_DEPTH), derived from registered count only; it SHALL NOT depend on lu_valid or on a same-cycle pop.
REQ-018 A push SHALL occur when lu_valid & lu_ready; lu_waddr==0 SHALL be handshaken but not pushed.
REQ-019 A simultaneous push and pop SHALL leave fifo_count unchanged and preserve FIFO order.
REQ-020 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 busy_mask bit k SHALL be set the cycle after issue_we with issue_waddr=k, k!=0; bit 0 SHALL always be 0.
REQ-022 busy_mask bit k SHALL clear in the same edge that drives a queue-sourced write to k onto rf_waddr.
REQ-023 When set and clear of the same bit coincide, set SHALL win.
REQ-024 A wait counter SHALL increment each cycle the queue is non-empty and no pop occurs, and reset to 0 on any pop or when the queue is empty.
REQ-025 stall_req SHALL be registered and asserted while the wait counter >= STARVE_LIMIT; it SHALL deassert the cycle after a pop.
REQ-026 While stall_req=1, the upstream pipeline SHALL hold alu_we=0 (system-level contract); the block SHALL NOT check this.

Reset
REQ-027 reset low SHALL asynchronously force rf_we=0, rf_waddr=0, rf_wdata=0, busy_mask=0, stall_req=0, fifo_count=0, both pointers=0, and wait counter=0.
REQ-028 Entries queued before reset SHALL be lost; lu_ready SHALL read 1 during and after reset.
REQ-029 Queue storage data need not be reset.

Structure
REQ-030 The shared package SHALL hold REG_ADDR_W=5, DATA_W=32, NUM_REGS=32, and the wb_req record (waddr, wdata).
REQ-031 The queue SHALL be a sub-module named wb_fifo (push/pop/full/empty/count); arbitration, scoreboard, and starvation logic SHALL reside in wb_arbiter.

Verification
REQ-032 The bench SHALL drive ALU-only writes (we=1, addr=3, data=0x11) -> next cycle rf_we=1, addr=3, data=0x11; and addr=0 -> rf_we=0.
REQ-033 The bench SHALL drive issue to r5, then lu push (5, 0xABCD) with alu_we=0 -> busy_mask[5]=1 after issue; write (5, 0xABCD) 2 cycles after push; busy_mask[5]=0 on the same edge.
REQ-034 The bench SHALL drive a push of 4 entries (r1..r4) while alu_we=1 continuously -> lu_ready=0 at count 4, stall_req=1 after 4 wait cycles; drop alu_we -> r1..r4 written in order.
REQ-035 The bench SHALL drive a simultaneous push and pop at count 2 -> count stays 2 and output order is preserved across pointer wrap.
REQ-036 The bench SHALL drive issue to r7 in the same cycle a queued r7 write pops -> busy_mask[7] remains 1.
REQ-037 The bench SHALL assert reset with 3 entries queued and busy_mask=0x0000_00F0 -> all outputs 0 immediately, lu_ready=1, and no stale writes after release.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared widths and the write-back request record
// used by the write-back arbiter and its result queue.
package wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] waddr;
        logic [DATA_W-1:0]     wdata;
    } wb_req_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(
        input logic [REG_ADDR_W-1:0] addr
    );
        return NUM_REGS'(1) << addr;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Result queue for long-latency write-backs.
// Storage is not reset; only pointers and occupancy are.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  wb_req_t    push_data,
    output wb_req_t    head,
    output logic       full,
    output logic       empty,
    output logic [3:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_req_t       mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == 4'(DEPTH));
    assign empty   = (count == 4'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= 4'd0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: ALU first, then queued
// long-latency results, with a busy scoreboard and starvation stall.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_we,
    input  logic [REG_ADDR_W-1:0] alu_waddr,
    input  logic [DATA_W-1:0]     alu_wdata,
    input  logic                  lu_valid,
    output logic                  lu_ready,
    input  logic [REG_ADDR_W-1:0] lu_waddr,
    input  logic [DATA_W-1:0]     lu_wdata,
    input  logic                  issue_we,
    input  logic [REG_ADDR_W-1:0] issue_waddr,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic [NUM_REGS-1:0]   busy_mask,
    output logic                  stall_req,
    output logic [3:0]            fifo_count
);

    localparam int WW = $clog2(STARVE_LIMIT + 1);
    localparam logic [WW-1:0] WAIT_LIMIT = WW'(STARVE_LIMIT);

    wb_req_t             lu_req;
    wb_req_t             head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                alu_sel;
    logic                pop;
    logic                push;
    logic [NUM_REGS-1:0] busy_next;
    logic [WW-1:0]       wait_cnt;
    logic [WW-1:0]       wait_next;

    assign lu_ready = !fifo_full;
    assign alu_sel  = alu_we && (alu_waddr != '0);
    assign pop      = !alu_sel && !fifo_empty;
    // r0 results complete the handshake but never occupy a slot
    assign push     = lu_valid && lu_ready && (lu_waddr != '0);

    assign lu_req.waddr = lu_waddr;
    assign lu_req.wdata = lu_wdata;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (lu_req),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // a new issue to a register outranks its retiring write
    always_comb begin
        busy_next = busy_mask;
        if (pop) begin
            busy_next = busy_next & ~reg_onehot(head.waddr);
        end
        if (issue_we && (issue_waddr != '0)) begin
            busy_next = busy_next | reg_onehot(issue_waddr);
        end
        busy_next[0] = 1'b0;
    end

    always_comb begin
        wait_next = wait_cnt;
        if (fifo_empty || pop) begin
            wait_next = '0;
        end else if (wait_cnt != WAIT_LIMIT) begin
            wait_next = wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            busy_mask <= '0;
            wait_cnt  <= '0;
            stall_req <= 1'b0;
        end else begin
            if (alu_sel) begin
                rf_we    <= 1'b1;
                rf_waddr <= alu_waddr;
                rf_wdata <= alu_wdata;
            end else if (pop) begin
                rf_we    <= 1'b1;
                rf_waddr <= head.waddr;
                rf_wdata <= head.wdata;
            end else begin
                rf_we    <= 1'b0;
            end
            busy_mask <= busy_next;
            wait_cnt  <= wait_next;
            stall_req <= (wait_next >= WAIT_LIMIT);
        end
    end

endmodule
